// File: rtl/mmio_bridge_if.sv
// Processor data-memory port as seen by the MMIO bridge.
// The master drives address, strobes and store data; the slave returns hit and load data.
interface mmio_bridge_if #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 32
) ();
  logic [ADDR_W-1:0] addr;
  logic              wen;
  logic              ren;
  logic [DATA_W-1:0] wdata;
  logic              hit;
  logic [DATA_W-1:0] rdata;

  modport master (
    output addr, wen, ren, wdata,
    input  hit, rdata
  );

  modport slave (
    input  addr, wen, ren, wdata,
    output hit, rdata
  );
endinterface

// File: rtl/mmio_bridge.sv
// MMIO hub on the data-memory port: NUM_CH latched output channels, NUM_CH input FIFOs
// drained by loads, and a STATUS word with occupancy and sticky write-1-to-clear overflow flags.
module mmio_bridge #(
  parameter int unsigned       NUM_CH    = 5,
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       ADDR_W    = 12,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 12'hF00,
  parameter int unsigned       IN_DEPTH  = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  mmio_bridge_if.slave             bus,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic [NUM_CH-1:0]        out_wen,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [NUM_CH-1:0]        in_valid,
  output logic [NUM_CH-1:0]        in_ready
);
  localparam int unsigned PtrW = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(IN_DEPTH + 1);

  logic [DATA_W-1:0] mem_q [NUM_CH][IN_DEPTH];
  logic [PtrW-1:0]   wptr_q [NUM_CH];
  logic [PtrW-1:0]   rptr_q [NUM_CH];
  logic [CntW-1:0]   cnt_q [NUM_CH];

  logic [ADDR_W-1:0]        off;
  logic                     is_ch, is_stat;
  logic [NUM_CH-1:0]        ch_sel, push, pop, nonempty;
  logic [NUM_CH-1:0]        ovf_q, ovf_d;
  logic [NUM_CH*DATA_W-1:0] out_data_q, out_data_d;
  logic [NUM_CH-1:0]        out_wen_q, out_wen_d;
  logic [DATA_W-1:0]        rdata_q, rdata_d, status;
  logic                     hit_q, hit_d;

  // Wrapping subtraction: addresses below BASE_ADDR land far above NUM_CH and miss.
  assign off     = bus.addr - BASE_ADDR;
  assign is_ch   = off < ADDR_W'(NUM_CH);
  assign is_stat = off == ADDR_W'(NUM_CH);

  always_comb begin
    ch_sel   = '0;
    nonempty = '0;
    in_ready = '0;
    push     = '0;
    pop      = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_sel[i]   = is_ch && (off == ADDR_W'(i));
      nonempty[i] = cnt_q[i] != '0;
      in_ready[i] = cnt_q[i] != CntW'(IN_DEPTH);
      push[i]     = in_valid[i] && in_ready[i];
      pop[i]      = bus.ren && ch_sel[i] && nonempty[i];
    end
  end

  always_comb begin
    status                 = '0;
    status[16 +: NUM_CH]   = ovf_q;
    status[NUM_CH-1:0]     = nonempty;

    rdata_d = '0;
    if (bus.ren && is_stat) rdata_d = status;
    for (int i = 0; i < NUM_CH; i++) begin
      if (pop[i]) rdata_d = mem_q[i][rptr_q[i]];
    end
    hit_d = (is_ch || is_stat) && (bus.ren || bus.wen);

    out_wen_d  = bus.wen ? ch_sel : '0;
    out_data_d = out_data_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (out_wen_d[i]) out_data_d[i*DATA_W +: DATA_W] = bus.wdata;
    end

    // Overflow set is applied after the clear so a same-cycle set wins.
    ovf_d = ovf_q;
    if (bus.wen && is_stat) ovf_d = ovf_d & ~bus.wdata[16 +: NUM_CH];
    ovf_d = ovf_d | (in_valid & ~in_ready);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      out_data_q <= '0;
      out_wen_q  <= '0;
      rdata_q    <= '0;
      hit_q      <= 1'b0;
      ovf_q      <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        wptr_q[i] <= '0;
        rptr_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
    end else begin
      out_data_q <= out_data_d;
      out_wen_q  <= out_wen_d;
      rdata_q    <= rdata_d;
      hit_q      <= hit_d;
      ovf_q      <= ovf_d;
      for (int i = 0; i < NUM_CH; i++) begin
        if (push[i]) wptr_q[i] <= wptr_q[i] + PtrW'(1);
        if (pop[i])  rptr_q[i] <= rptr_q[i] + PtrW'(1);
        cnt_q[i] <= cnt_q[i] + CntW'(push[i]) - CntW'(pop[i]);
      end
    end
  end

  // Storage needs no reset; pointers and counts define validity.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (push[i]) mem_q[i][wptr_q[i]] <= in_data[i*DATA_W +: DATA_W];
    end
  end

  assign out_data  = out_data_q;
  assign out_wen   = out_wen_q;
  assign bus.rdata = rdata_q;
  assign bus.hit   = hit_q;
endmodule

// File: doc/mmio_bridge.md
Name: mmio_bridge

Overview:
- Parametrised memory-mapped I/O hub on the processor data-memory port; replaces the fixed five-channel I/O path beside the data RAM.
- Decodes a word-address window at BASE_ADDR and provides NUM_CH output channels, each a latched register with a one-cycle write strobe.
- Provides NUM_CH input channels, each a valid/ready FIFO the processor drains by reading.
- A status word reports per-channel FIFO occupancy and sticky overflow flags.

Parameters:
- NUM_CH, 5, number of I/O channels, 1..16
- DATA_W, 32, channel and bus data width
- ADDR_W, 12, data-memory word-address width
- BASE_ADDR, 12'hF00, first word address of the window
- IN_DEPTH, 4, input FIFO depth per channel, power of 2, at least 2

Ports:
- clock  in  1  system clock; all state updates on the rising edge
- reset  in  1  synchronous, active-low reset (0 = reset)
- addr  in  ADDR_W  data-memory word address
- wen  in  1  processor store strobe
- ren  in  1  processor load strobe; loads pop FIFOs only when this is high
- wdata  in  DATA_W  store data
- hit  out  1  registered: previous cycle's addr was inside the window; wrapper uses it to select rdata over RAM data
- rdata  out  DATA_W  registered load data
- out_data  out  NUM_CH*DATA_W  channel i output latch at bits [i*DATA_W +: DATA_W]
- out_wen  out  NUM_CH  one-cycle strobe per channel on store
- in_data  in  NUM_CH*DATA_W  peripheral push data, same packing as out_data
- in_valid  in  NUM_CH  peripheral push request
- in_ready  out  NUM_CH  channel FIFO not full (registered count)

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low.
- Reset state: out_data=0, out_wen=0, rdata=0, hit=0, all FIFOs empty, in_ready all 1, overflow flags 0. Reset takes priority over every simultaneous event. A reset mid-transfer discards FIFO contents.
- Decode: off = addr - BASE_ADDR. The window covers off 0..NUM_CH.
  - off < NUM_CH: channel off.
  - off = NUM_CH: STATUS.
  - Anything else: no hit. Stores are ignored and loads do not pop.
- Store to channel i: out_data[i] <= wdata at the next edge; out_wen[i] is high for exactly the following cycle. Back-to-back stores give back-to-back strobes. The latch holds until the next store.
- Load from channel i (ren=1):
  - Non-empty FIFO: rdata <= head and the FIFO pops, 1-cycle latency.
  - Empty FIFO: rdata <= 0, no pop, no pointer change.
- STATUS read, rdata <= {zero-pad, ovf[NUM_CH-1:0] at bits 16+, nonempty[NUM_CH-1:0] at bits 0+}.
- STATUS write: write-1-to-clear for overflow bits 16+; the other bits are ignored.
- hit <= (addr in window) && (ren || wen), registered alongside rdata. A load outside the window sets rdata <= 0 and hit <= 0.
- Input FIFO, per channel:
  - Storage: circular buffer of IN_DEPTH entries, wrap-around pointers, count 0..IN_DEPTH.
  - in_ready[i] = (count < IN_DEPTH).
  - Push occurs when in_valid && in_ready.
  - Push and pop in the same cycle: both occur and count is unchanged. When full, in_ready=0, so a same-cycle pop does not admit a push that cycle.
  - When empty, a pop is suppressed and a same-cycle push is still accepted.
  - in_valid && !in_ready sets ovf[i] (sticky). The data is not stored.
  - Set and W1C on the same cycle: set wins.
- Simultaneous wen and ren at the same address: the store takes effect (channel latch or STATUS clear) and the load also returns data. For a channel, the load returns FIFO data, not the latch.
- Channels are independent. Activity on one channel never stalls another.

Test Plan:
- Release reset, then store 0xDEADBEEF to 0xF02 -> next cycle out_data[2]=0xDEADBEEF, out_wen=5'b00100 for one cycle, then 0. Other latches stay 0.
- Push 0x11, 0x22 on ch0; ren at 0xF00 twice -> rdata=0x11 then 0x22, hit=1 both cycles. A third read -> rdata=0 and the count stays 0.
- Push 5 words on ch1 with IN_DEPTH=4 -> in_ready[1]=0 after 4 pushes. The 5th sets STATUS bit 17. Read 0xF05 -> 0x00020002. Store 0x00020000 to 0xF05 -> bit 17 clears.
- ch3 full; pop and assert in_valid in the same cycle -> push refused, ovf[3] set, count=3. Next cycle push accepted, count=4. Data order is preserved across pointer wrap.
- Load from 0xEFF and 0xF06 -> hit=0, rdata=0, no FIFO pops. Store to 0xF06 -> no out_wen.
- Assert reset=0 mid-stream with FIFOs partly full and out_data set -> next edge: all outputs 0, in_ready all 1, STATUS reads 0.
